if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds the ID-stage decoder `ctrl`. Next-PC selection consumes the `NPCOp` encoding that `ctrl` produces, returned from EX together with the computed targets. The hazard unit's `stall` and `flush` controls, and EX-stage redirects, are resolved here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `stall` in 1: load-use hold from the hazard unit.
- `flush` in 1: external IF/ID kill.
- `ex_npcop` in 3: EX-stage `NPCOp` (000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR), already qualified with `Zero`.
- `ex_pc` in 32: PC of the instruction in EX.
- `ex_imm` in 32: extended immediate of the instruction in EX.
- `ex_aluout` in 32: ALU result (rs1+imm) used for JALR.
- `imem_addr` out 32: instruction-memory address; equals `pc`.
- `imem_rdata` in 32: combinational instruction read of `imem_addr`.
- `pc` out 32: current fetch PC.
- `if_id_pc` out 32: registered PC of the instruction in ID.
- `if_id_inst` out 32: registered instruction in ID.
- `if_id_valid` out 1: 0 marks a bubble.
- `redirect` out 1: combinational, high when `ex_npcop != 0`; the downstream ID/EX register uses it to kill ID.
- `misalign_err` out 1: sticky, set when a taken target has bits [1:0] != 0.

## Operation
- **Target select** (combinational priority when several `ex_npcop` bits are set): JALR > JUMP > BRANCH.
  - JALR: `ex_aluout & ~32'h1`.
  - JUMP or BRANCH: `ex_pc + ex_imm`, 32-bit wrap, no carry out.
- **Next PC**, in priority order:
  - `redirect`: the target.
  - else `stall`: hold `pc`.
  - else: `pc + 4`, wrapping 32'hFFFF_FFFC to 0.
  - `flush` alone does not change the PC.
- **IF/ID register**, in priority order:
  - `redirect | flush`: load `inst = NOP_INST`, `valid = 0`, `if_id_pc = pc`.
  - else `stall`: hold all three fields.
  - else: load `imem_rdata`, `pc`, `valid = 1`.
- **`misalign_err`**: set on the edge at which a redirect with `target[1:0] != 0` is taken. The PC still loads the target unmodified. The flag clears only on reset.
- **Reset**, asynchronous, while `rstn = 0`:
  - `pc = RESET_PC`.
  - `if_id_inst = NOP_INST`, `if_id_pc = 0`, `if_id_valid = 0`.
  - `misalign_err = 0`.
  - Reset overrides every other input, including mid-redirect and mid-stall.

## Timing
- Fetch latency: the instruction at `pc` appears on `if_id_inst` one edge after it is addressed.
- Redirect in cycle n:
  - `pc = target` after edge n.
  - IF/ID holds a bubble during n+1.
  - The target instruction is in ID during n+2.
  - Two-cycle penalty; the ID kill is performed downstream via `redirect`.
- Stall: a held cycle repeats `pc` and the IF/ID contents exactly. Consecutive stalls may last any length.
- Simultaneous `stall` and `redirect`: redirect wins both PC and IF/ID. Nothing is held, so no instruction is lost.
- Simultaneous `stall` and `flush` without redirect: PC holds, IF/ID becomes a bubble.
- First edge after reset release: IF/ID captures the instruction at `RESET_PC`, `valid = 1`, and `pc = RESET_PC + 4`.
- `redirect` and `imem_addr` are purely combinational. Every other output is registered.

## Test plan
- **Reset and sequential fetch.** Release reset with `RESET_PC = 0` and memory word k = 32'h100+k. Required: `pc` steps 0,4,8; `if_id_inst` = 0x100, 0x101 with `valid = 1`.
- **Taken branch.** `ex_npcop = 001`, `ex_pc = 0x40`, `ex_imm = 0xFFFF_FFF0`. Required: next `pc = 0x30`; IF/ID = `NOP_INST`, `valid = 0` for one cycle; `redirect = 1` in that cycle only.
- **JALR.** `ex_npcop = 100`, `ex_aluout = 0x0000_0203`. Required: `pc = 0x202` and `misalign_err` set.
- **Stall, then stall with redirect.** Three-cycle `stall`: required `pc` and IF/ID frozen. Then `stall` with `ex_npcop = 010`, `ex_pc = 0x10`, `ex_imm = 8`: required `pc = 0x18` and a bubble.
- **Flush without redirect.** `flush` with `pc = 0x20`. Required: IF/ID bubble, `if_id_pc = 0x20`, next `pc = 0x24`. Then `pc = 0xFFFF_FFFC` with no stall: required wrap to 0.
- **Reset mid-operation.** Assert `rstn = 0` asynchronously between edges during a redirect. Required: all outputs return to reset values immediately; `misalign_err = 0`.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: RISC-V fetch stage holding the PC, selecting the next PC and loading the IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        flush,
    input  logic [2:0]  ex_npcop,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_aluout,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        redirect,
    output logic        misalign_err
);
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        bubble;
    logic        misaligned;

    assign imem_addr = pc;

    // Redirect target (JALR outranks JUMP/BRANCH) and next-PC priority: redirect, stall, sequential
    always_comb begin
        target     = ex_npcop[2] ? (ex_aluout & ~32'h1) : ex_pc + ex_imm;
        redirect   = |ex_npcop;
        pc_next    = redirect ? target : stall ? pc : pc + 32'd4;
        bubble     = redirect | flush;
        misaligned = redirect & (target[1:0] != 2'b00);
    end

    // Program counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc <= RESET_PC;
        else       pc <= pc_next;
    end

    // IF/ID register: bubble on redirect or flush, hold on stall, otherwise capture the fetch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (bubble) begin
            if_id_pc    <= pc;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           misalign_err <= 1'b0;
        else if (misaligned) misalign_err <= 1'b1;
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with directed vectors and hand-computed expectations
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  ex_npcop = 3'b000;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] ex_imm = 32'h0;
    logic [31:0] ex_aluout = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        redirect;
    logic        misalign_err;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        v;
        logic        mis;
        logic        red;
        logic        chk_red;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    event sample_ev;

    if_stage dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .ex_npcop(ex_npcop), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_aluout(ex_aluout),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .redirect(redirect), .misalign_err(misalign_err)
    );

    // Memory word k holds 32'h100 + k
    assign imem_rdata = 32'h100 + (imem_addr >> 2);

    always #5 clk = ~clk;

    function automatic exp_t e(input string n, input logic [31:0] p, input logic [31:0] ip,
                               input logic [31:0] in, input logic v, input logic mis, input logic red);
        exp_t x;
        x.name = n; x.pc = p; x.ipc = ip; x.inst = in; x.v = v; x.mis = mis; x.red = red; x.chk_red = 1'b1;
        return x;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s.%s: got %h required %h", n, f, act, req);
    endtask

    // Monitor: after each rising edge (or an explicit asynchronous sample), pop and compare
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.name, "pc", pc, x.pc);
                chk(x.name, "imem_addr", imem_addr, x.pc);
                chk(x.name, "if_id_pc", if_id_pc, x.ipc);
                chk(x.name, "if_id_inst", if_id_inst, x.inst);
                chk(x.name, "if_id_valid", {31'h0, if_id_valid}, {31'h0, x.v});
                chk(x.name, "misalign_err", {31'h0, misalign_err}, {31'h0, x.mis});
                if (x.chk_red) chk(x.name, "redirect", {31'h0, redirect}, {31'h0, x.red});
            end
        end
    end

    task automatic step(input logic r, input logic st, input logic fl, input logic [2:0] op,
                        input logic [31:0] epc, input logic [31:0] eimm, input logic [31:0] ealu,
                        input exp_t x);
        @(negedge clk);
        rstn = r; stall = st; flush = fl; ex_npcop = op;
        ex_pc = epc; ex_imm = eimm; ex_aluout = ealu;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        step(0, 0, 0, 3'b000, 0, 0, 0, e("reset", 32'h0, 32'h0, NOP, 0, 0, 0));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("fetch0", 32'h4, 32'h0, 32'h100, 1, 0, 0));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("fetch1", 32'h8, 32'h4, 32'h101, 1, 0, 0));
        step(1, 0, 0, 3'b001, 32'h40, 32'hFFFF_FFF0, 0, e("branch", 32'h30, 32'h8, NOP, 0, 0, 1));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("br_target", 32'h34, 32'h30, 32'h10C, 1, 0, 0));
        step(1, 0, 0, 3'b100, 0, 0, 32'h0000_0203, e("jalr", 32'h202, 32'h34, NOP, 0, 1, 1));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("jalr_tgt", 32'h206, 32'h202, 32'h180, 1, 1, 0));
        step(1, 1, 0, 3'b000, 0, 0, 0, e("stall1", 32'h206, 32'h202, 32'h180, 1, 1, 0));
        step(1, 1, 0, 3'b000, 0, 0, 0, e("stall2", 32'h206, 32'h202, 32'h180, 1, 1, 0));
        step(1, 1, 0, 3'b000, 0, 0, 0, e("stall3", 32'h206, 32'h202, 32'h180, 1, 1, 0));
        step(1, 1, 0, 3'b010, 32'h10, 32'h8, 0, e("stall_jump", 32'h18, 32'h206, NOP, 0, 1, 1));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("jump_tgt", 32'h1C, 32'h18, 32'h106, 1, 1, 0));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("seq_1c", 32'h20, 32'h1C, 32'h107, 1, 1, 0));
        step(1, 0, 1, 3'b000, 0, 0, 0, e("flush", 32'h24, 32'h20, NOP, 0, 1, 0));
        step(1, 1, 1, 3'b000, 0, 0, 0, e("stall_flush", 32'h24, 32'h24, NOP, 0, 1, 0));
        step(1, 0, 0, 3'b010, 32'hFFFF_FFF0, 32'hC, 0, e("jump_top", 32'hFFFF_FFFC, 32'h24, NOP, 0, 1, 1));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("wrap", 32'h0, 32'hFFFF_FFFC, 32'h4000_00FF, 1, 1, 0));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("after_wrap", 32'h4, 32'h0, 32'h100, 1, 1, 0));
        step(1, 0, 0, 3'b111, 32'h100, 32'h100, 32'h0000_0081, e("prio_jalr", 32'h80, 32'h4, NOP, 0, 1, 1));
        // Asynchronous reset between edges while a redirect is being presented
        @(negedge clk);
        ex_npcop = 3'b001; ex_pc = 32'h40; ex_imm = 32'h4; stall = 1'b0; flush = 1'b0;
        #2;
        rstn = 1'b0;
        x = e("async_reset", 32'h0, 32'h0, NOP, 0, 0, 0);
        x.chk_red = 1'b0;
        q.push_back(x);
        ->sample_ev;
        step(0, 0, 0, 3'b000, 0, 0, 0, e("held_reset", 32'h0, 32'h0, NOP, 0, 0, 0));
        step(1, 0, 0, 3'b000, 0, 0, 0, e("refetch0", 32'h4, 32'h0, 32'h100, 1, 0, 0));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d entries left required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
